button_click_decoder: RTL and testbench

- Consumes the one-cycle press pulses from the button synchroniser/edge-detect stage.
- Classifies each gesture as a single click or a double click within a configurable time window.
- Rejects contact bounce with a lockout interval after every accepted press.
- Emits one-cycle registered event pulses to the control logic downstream.

---
 rtl/button_pkg.sv | 15 +
 rtl/button_click_decoder_cycle_timer.sv | 27 ++
 rtl/button_click_decoder.sv | 101 ++++++++++
 tb/tb_button_click_decoder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and default timing for the button click decoder.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    WAIT2 = 2'd2,
    LOCK2 = 2'd3
  } click_state_t;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned LOCKOUT_CYCLES_DEF = 50_000;      // 1 ms at CLK_HZ
  localparam int unsigned WINDOW_CYCLES_DEF  = 15_000_000;  // 300 ms at CLK_HZ

endpackage

// File: rtl/button_click_decoder_cycle_timer.sv
// Clearable up-counter with an equality compare against a caller-supplied terminal value.
// hit is combinational on the registered count; no handshake, counts every cycle unless cleared.
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/button_click_decoder.sv
// Classifies press pulses into single/double clicks with a post-press bounce lockout.
// Outputs are registered one-cycle pulses; single_o lands WINDOW_CYCLES+1 after the first press, double_o one cycle after the second.
module button_click_decoder
  import button_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter int unsigned WINDOW_CYCLES  = WINDOW_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_i,
  output logic single_o,
  output logic double_o,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_TERM  = CNT_W'(WINDOW_CYCLES - 1);

  click_state_t     state;
  click_state_t     state_nxt;
  logic             clr;
  logic             hit;
  logic [CNT_W-1:0] term;
  logic             single_nxt;
  logic             double_nxt;
  logic             busy_nxt;

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .term  (term),
    .hit   (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      single_o <= 1'b0;
      double_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      single_o <= single_nxt;
      double_o <= double_nxt;
      busy_o   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    clr        = 1'b0;
    term       = LOCK_TERM;
    single_nxt = 1'b0;
    double_nxt = 1'b0;

    case (state)
      // Counter is held at zero while idle so the LOCK1 entry starts from 0.
      IDLE: begin
        clr = 1'b1;
        if (press_i) begin
          state_nxt = LOCK1;
        end
      end
      LOCK1: begin
        if (hit) begin
          state_nxt = WAIT2;
        end
      end
      // The counter keeps running from LOCK1, so the window is measured from the first press.
      WAIT2: begin
        term = WIN_TERM;
        if (press_i) begin
          double_nxt = 1'b1;
          state_nxt  = LOCK2;
          clr        = 1'b1;
        end else if (hit) begin
          single_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      LOCK2: begin
        if (hit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase

    // Busy also covers the cycle in which the decision pulse is presented.
    busy_nxt = (state != IDLE) || (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_button_click_decoder.sv
// Directed table of click gestures with LOCKOUT_CYCLES=4, WINDOW_CYCLES=20, checked cycle by cycle.
module tb_button_click_decoder;

  logic clk;
  logic rst_n;
  logic press;
  logic single_o;
  logic double_o;
  logic busy_o;

  int n_cmp;
  int n_bad;

  localparam int NCYC = 60;

  typedef struct {
    string       name;
    logic [63:0] mask;
    int          rst_cyc;
    int          s1;
    int          s2;
    int          d1;
    int          b0s;
    int          b0e;
    int          b1s;
    int          b1e;
  } vec_t;

  vec_t vecs[10];

  button_click_decoder #(
    .LOCKOUT_CYCLES (4),
    .WINDOW_CYCLES  (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .press_i  (press),
    .single_o (single_o),
    .double_o (double_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] at3(input int a, input int b, input int c);
    logic [63:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input string n, input logic [63:0] m, input int rc,
                              input int s1, input int s2, input int d1,
                              input int b0s, input int b0e, input int b1s, input int b1e);
    vec_t v;
    v.name = n; v.mask = m; v.rst_cyc = rc;
    v.s1 = s1; v.s2 = s2; v.d1 = d1;
    v.b0s = b0s; v.b0e = b0e; v.b1s = b1s; v.b1e = b1e;
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0b, required %0b", nm, c, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic es, ed, eb;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst_n = !(c < 4 || c == v.rst_cyc);
      press = v.mask[c];
      @(negedge clk);
      if (c >= 1) begin
        es = (c == v.s1) || (c == v.s2);
        ed = (c == v.d1);
        eb = (c >= v.b0s && c <= v.b0e) || (c >= v.b1s && c <= v.b1e);
        chk({v.name, ".single"}, c, single_o, es);
        chk({v.name, ".double"}, c, double_o, ed);
        chk({v.name, ".busy"}, c, busy_o, eb);
        chk({v.name, ".excl"}, c, single_o & double_o, 1'b0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    press = 1'b0;

    //              name           presses             rst  s1  s2  d1  busy ranges
    vecs[0] = mk("single",       at3(10, -1, -1),      -1, 31, -1, -1, 11, 31, -1, -1);
    vecs[1] = mk("double",       at3(10, 18, -1),      -1, -1, -1, 19, 11, 23, -1, -1);
    vecs[2] = mk("bounce_1",     64'h0000_0000_0000_7C00, -1, 31, -1, -1, 11, 31, -1, -1);
    vecs[3] = mk("bounce_2",     at3(10, 15, -1),      -1, -1, -1, 16, 11, 20, -1, -1);
    vecs[4] = mk("window_edge",  at3(10, 30, -1),      -1, -1, -1, 31, 11, 35, -1, -1);
    vecs[5] = mk("reset_mid",    at3(10, 20, -1),      15, 41, -1, -1, 11, 15, 21, 41);
    vecs[6] = mk("lock2_20",     at3(10, 18, 20),      -1, -1, -1, 19, 11, 23, -1, -1);
    vecs[7] = mk("lock2_22",     at3(10, 18, 22),      -1, -1, -1, 19, 11, 23, -1, -1);
    vecs[8] = mk("lock2_24",     at3(10, 18, 24),      -1, 45, -1, 19, 11, 23, 25, 45);
    vecs[9] = mk("press_on_single", at3(10, 31, -1),   -1, 31, 52, -1, 11, 52, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Presses held during reset must not start a gesture.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      press = 1'b1;
      @(negedge clk);
      if (c >= 1) begin
        chk("rst_press.busy", c, busy_o, 1'b0);
        chk("rst_press.single", c, single_o, 1'b0);
        chk("rst_press.double", c, double_o, 1'b0);
      end
    end
    for (int c = 4; c < 8; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      press = 1'b0;
      @(negedge clk);
      chk("rst_press.idle", c, busy_o, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
